// File: rtl/block_field_generator_if.sv
// Bus bundle between the game control / collision detector side and the obstacle field generator.
// The master side drives the level request and frame tick; the slave side returns the field.
interface block_field_generator_if #(
  parameter int NUM_BLOCKS = 27,
  parameter int COORD_W    = 11
);
  logic                          start;
  logic [15:0]                   level_seed;
  logic                          update_screen;
  logic [NUM_BLOCKS*COORD_W-1:0] block_x_pos;
  logic [NUM_BLOCKS*COORD_W-1:0] block_y_pos;
  logic [COORD_W-1:0]            move_counter;
  logic                          busy;
  logic                          field_ready;
  logic                          level_done;

  modport master (
    output start, level_seed, update_screen,
    input  block_x_pos, block_y_pos, move_counter, busy, field_ready, level_done
  );

  modport slave (
    input  start, level_seed, update_screen,
    output block_x_pos, block_y_pos, move_counter, busy, field_ready, level_done
  );
endinterface

// File: rtl/block_field_generator.sv
// Runner-game obstacle field: loads one LFSR-derived block per clock, then scrolls
// the field on each frame tick until it has moved END_MARGIN past the last block.
module block_field_generator #(
  parameter int NUM_BLOCKS = 27,
  parameter int COORD_W    = 11,
  parameter int SPEED      = 1,
  parameter int FIRST_X    = 160,
  parameter int MIN_GAP    = 20,
  parameter int GROUND_Y   = 99,
  parameter int STEP_Y     = 10,
  parameter int END_MARGIN = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  block_field_generator_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q [NUM_BLOCKS];
  logic [COORD_W-1:0] x_d [NUM_BLOCKS];
  logic [COORD_W-1:0] y_q [NUM_BLOCKS];
  logic [COORD_W-1:0] y_d [NUM_BLOCKS];
  logic [IDX_W-1:0]   index_q, index_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         prev_h_q, prev_h_d;
  logic [COORD_W-1:0] last_x_q, last_x_d;
  logic [COORD_W-1:0] end_x_q, end_x_d;
  logic [COORD_W-1:0] distance_q, distance_d;
  logic               busy_q, busy_d;
  logic               field_ready_q, field_ready_d;
  logic               level_done_q, level_done_d;

  logic [COORD_W-1:0] gap_s, new_x_s, new_y_s;
  logic [2:0]         h_raw_s, h_s, h_cap_s;
  logic               fb_s;

  // Geometry of the block currently being loaded, taken from the present LFSR value
  always_comb begin
    gap_s   = COORD_W'(MIN_GAP) + COORD_W'({lfsr_q[3:0], 1'b0});
    new_x_s = (index_q == '0) ? COORD_W'(FIRST_X) : (last_x_q + gap_s);
    h_raw_s = {1'b0, lfsr_q[5:4]};
    h_cap_s = {1'b0, prev_h_q} + 3'd1;
    if (h_raw_s == 3'd3) begin
      h_s = 3'd0;
    end else if (h_raw_s > h_cap_s) begin
      h_s = h_cap_s;  // a block may rise at most one level above its predecessor
    end else begin
      h_s = h_raw_s;
    end
    new_y_s = COORD_W'(GROUND_Y) - COORD_W'(STEP_Y) * COORD_W'(h_s);
    fb_s    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  // Next-state logic: load sequencing, scroll tracking and restart handling
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    index_d    = index_q;
    lfsr_d     = lfsr_q;
    prev_h_d   = prev_h_q;
    last_x_d   = last_x_q;
    end_x_d    = end_x_q;
    distance_d = distance_q;
    case (state_q)
      LOAD: begin
        x_d[index_q] = new_x_s;
        y_d[index_q] = new_y_s;
        last_x_d     = new_x_s;
        prev_h_d     = h_s[1:0];
        lfsr_d       = {lfsr_q[14:0], fb_s};
        if (index_q == IDX_W'(NUM_BLOCKS - 1)) begin
          state_d = RUN;
          end_x_d = new_x_s + COORD_W'(END_MARGIN);
        end else begin
          index_d = index_q + IDX_W'(1);
        end
      end
      RUN: begin
        if (bus.update_screen) begin
          distance_d = distance_q + COORD_W'(SPEED);
          if (distance_d >= end_x_q) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          distance_d = distance_q;
        end
      end
      IDLE, DONE: begin
        state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A restart overrides whatever the current state decided, including a RUN tick
    if (bus.start && (state_q != LOAD)) begin
      state_d    = LOAD;
      index_d    = '0;
      lfsr_d     = (bus.level_seed == 16'h0000) ? 16'hACE1 : bus.level_seed;
      distance_d = '0;
      prev_h_d   = 2'd0;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        x_d[k] = {COORD_W{1'b1}};
        y_d[k] = {COORD_W{1'b1}};
      end
    end else begin
      index_d = index_d;
    end
    busy_d        = (state_d == LOAD);
    field_ready_d = (state_d == RUN);
    level_done_d  = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      lfsr_q        <= 16'h0000;
      prev_h_q      <= 2'd0;
      last_x_q      <= '0;
      end_x_q       <= '0;
      distance_q    <= '0;
      busy_q        <= 1'b0;
      field_ready_q <= 1'b0;
      level_done_q  <= 1'b0;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        x_q[k] <= {COORD_W{1'b1}};
        y_q[k] <= {COORD_W{1'b1}};
      end
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      lfsr_q        <= lfsr_d;
      prev_h_q      <= prev_h_d;
      last_x_q      <= last_x_d;
      end_x_q       <= end_x_d;
      distance_q    <= distance_d;
      busy_q        <= busy_d;
      field_ready_q <= field_ready_d;
      level_done_q  <= level_done_d;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_pack
    assign bus.block_x_pos[k*COORD_W +: COORD_W] = x_q[k];
    assign bus.block_y_pos[k*COORD_W +: COORD_W] = y_q[k];
  end

  // field_ready_q is high exactly while in RUN, so the tick sees the increment in its own cycle
  assign bus.move_counter = field_ready_q ? COORD_W'(SPEED) : '0;
  assign bus.busy         = busy_q;
  assign bus.field_ready  = field_ready_q;
  assign bus.level_done   = level_done_q;
endmodule
